// File: rtl/dual_lane_skid_buffer.sv
// Two-lane elastic register slice; each lane is a 2-entry valid/ready
// skid buffer with registered outputs and an optional lockstep mode.
//
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   in{1,2}_data/valid    upstream payload/valid per lane
//   in{1,2}_ready         upstream ready (registered state only)
//   out{1,2}_data/valid   downstream payload/valid (from main register)
//   out{1,2}_ready        downstream ready per lane
module dual_lane_skid_buffer #(
    parameter int WIDTH    = 32,
    parameter int LOCKSTEP = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
);

    logic             rdy_en;
    logic [1:0]       mv;
    logic [1:0]       sv;
    logic [1:0]       vin;
    logic [1:0]       ordy;
    logic [1:0]       rdy;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       ovld;
    logic [WIDTH-1:0] din [2];
    logic [WIDTH-1:0] md  [2];
    logic [WIDTH-1:0] sd  [2];

    assign din[0] = in1_data;
    assign din[1] = in2_data;
    assign vin    = {in2_valid, in1_valid};
    assign ordy   = {out2_ready, out1_ready};

    // Ready depends only on flops, so downstream ready never reaches
    // upstream ready combinationally.
    assign rdy  = {2{rdy_en}} & ~sv;
    assign push = vin & rdy;

    generate
        if (LOCKSTEP != 0) begin : g_lock
            logic both;
            assign both = &mv;
            assign ovld = {2{both}};
            // A lone ready must not retire one half of a pair.
            assign pop  = {2{both & (&ordy)}};
        end else begin : g_free
            assign ovld = mv;
            assign pop  = mv & ordy;
        end
    endgenerate

    // Holds off acceptance until the first edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mv <= '0;
            sv <= '0;
            for (int i = 0; i < 2; i++) begin
                md[i] <= '0;
                sd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pop[i]) begin
                    // Skid drains first; push is impossible while skid is full.
                    if (sv[i]) begin
                        md[i] <= sd[i];
                        sv[i] <= 1'b0;
                    end else if (push[i]) begin
                        md[i] <= din[i];
                    end else begin
                        mv[i] <= 1'b0;
                    end
                end else if (push[i]) begin
                    if (mv[i]) begin
                        sd[i] <= din[i];
                        sv[i] <= 1'b1;
                    end else begin
                        md[i] <= din[i];
                        mv[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign in1_ready  = rdy[0];
    assign in2_ready  = rdy[1];
    assign out1_valid = ovld[0];
    assign out2_valid = ovld[1];
    assign out1_data  = md[0];
    assign out2_data  = md[1];

endmodule

// File: tb/tb_dual_lane_skid_buffer.sv
// Bench for dual_lane_skid_buffer: a free-running and a lockstep instance
// share stimulus and are checked against per-lane queue models.
module tb_dual_lane_skid_buffer;

    logic       CLK;
    logic       RST_N;
    logic [1:0] iv;
    logic [1:0] ordy;
    logic [7:0] id0;
    logic [7:0] id1;
    logic [3:0] ov;
    logic [3:0] ir;
    logic [7:0] od [4];

    int nchk;
    int nerr;

    // Model: one queue per (instance, lane); index = inst*2 + lane.
    logic [7:0] mq [4][$];
    bit         mrdy;

    dual_lane_skid_buffer #(.WIDTH(8), .LOCKSTEP(0)) u_free (
        .CLK(CLK), .RST_N(RST_N),
        .in1_data(id0), .in1_valid(iv[0]), .in1_ready(ir[0]),
        .in2_data(id1), .in2_valid(iv[1]), .in2_ready(ir[1]),
        .out1_data(od[0]), .out1_valid(ov[0]), .out1_ready(ordy[0]),
        .out2_data(od[1]), .out2_valid(ov[1]), .out2_ready(ordy[1])
    );

    dual_lane_skid_buffer #(.WIDTH(8), .LOCKSTEP(1)) u_lock (
        .CLK(CLK), .RST_N(RST_N),
        .in1_data(id0), .in1_valid(iv[0]), .in1_ready(ir[2]),
        .in2_data(id1), .in2_valid(iv[1]), .in2_ready(ir[3]),
        .out1_data(od[2]), .out1_valid(ov[2]), .out1_ready(ordy[0]),
        .out2_data(od[3]), .out2_valid(ov[3]), .out2_ready(ordy[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       i1v;
        logic [7:0] i1d;
        logic       o1r;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ir;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit mvalid(input int idx);
        if (idx < 2) return mq[idx].size() > 0;
        return (mq[2].size() > 0) && (mq[3].size() > 0);
    endfunction

    function automatic bit mready(input int idx);
        return mrdy && (mq[idx].size() < 2);
    endfunction

    task automatic model_check();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid%0d", i), 32'(ov[i]), 32'(mvalid(i)));
            chk($sformatf("ready%0d", i), 32'(ir[i]), 32'(mready(i)));
            if (mvalid(i))
                chk($sformatf("data%0d", i), 32'(od[i]), 32'(mq[i][0]));
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        mrdy = 1'b0;
    endtask

    // One clock: decide transfers from model state, step, then check.
    task automatic cycle();
        bit pu [4];
        bit po [4];
        for (int i = 0; i < 4; i++) begin
            int l;
            l = i % 2;
            pu[i] = RST_N && iv[l] && mready(i);
            po[i] = RST_N && mvalid(i) &&
                    ((i < 2) ? ordy[l] : (ordy[0] && ordy[1]));
        end
        @(posedge CLK);
        #1;
        if (!RST_N) begin
            model_clear();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (po[i]) void'(mq[i].pop_front());
                if (pu[i]) mq[i].push_back((i % 2) ? id1 : id0);
            end
            mrdy = 1'b1;
        end
        model_check();
    endtask

    // Entered and left at posedge+1; reset asserted mid-period.
    task automatic pulse_reset();
        #2;
        RST_N = 1'b0;
        model_clear();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_valid%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_data%0d", i), 32'(od[i]), 32'd0);
            chk($sformatf("rst_ready%0d", i), 32'(ir[i]), 32'd0);
        end
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        cycle();
    endtask

    initial begin
        nchk  = 0;
        nerr  = 0;
        RST_N = 1'b0;
        iv    = '0;
        ordy  = '0;
        id0   = '0;
        id1   = '0;
        model_clear();

        tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1};
        tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1};
        tbl[3]  = '{1'b1, 8'h04, 1'b1, 1'b1, 8'h04, 1'b1};
        tbl[4]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 1'b1};
        tbl[5]  = '{1'b1, 8'h06, 1'b1, 1'b1, 8'h06, 1'b1};
        tbl[6]  = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b1};
        tbl[7]  = '{1'b1, 8'h08, 1'b1, 1'b1, 8'h08, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[9]  = '{1'b1, 8'h0A, 1'b0, 1'b1, 8'h0A, 1'b1};
        tbl[10] = '{1'b1, 8'h0B, 1'b0, 1'b1, 8'h0A, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h0A, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0B, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};

        // Reset hold and release.
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("init_valid%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("init_data%0d", i), 32'(od[i]), 32'd0);
            chk($sformatf("init_ready%0d", i), 32'(ir[i]), 32'd0);
        end
        for (int c = 0; c < 3; c++) cycle();
        #4;
        RST_N = 1'b1;
        #1;
        chk("rel_ready_pre", 32'(ir), 32'h0);
        cycle();
        chk("rel_ready_post", 32'(ir), 32'hF);

        // Streaming then stall/skid on lane 1 of the free instance.
        for (int t = 0; t < 14; t++) begin
            iv   = {1'b0, tbl[t].i1v};
            id0  = tbl[t].i1d;
            ordy = {1'b1, tbl[t].o1r};
            cycle();
            chk($sformatf("tbl%0d_valid", t), 32'(ov[0]), 32'(tbl[t].e_ov));
            if (tbl[t].e_ov)
                chk($sformatf("tbl%0d_data", t), 32'(od[0]),
                    32'(tbl[t].e_od));
            chk($sformatf("tbl%0d_ready", t), 32'(ir[0]), 32'(tbl[t].e_ir));
            chk($sformatf("tbl%0d_lane2", t), 32'(ov[1]), 32'd0);
        end

        // Lockstep pairing.
        iv   = '0;
        ordy = '0;
        pulse_reset();
        iv   = 2'b01;
        id0  = 8'h11;
        ordy = 2'b01;
        cycle();
        chk("ls_wait_v1", 32'(ov[2]), 32'd0);
        iv = 2'b00;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("ls_idle_v", 32'(ov[3:2]), 32'd0);
        end
        iv  = 2'b10;
        id1 = 8'h22;
        cycle();
        chk("ls_pair_v", 32'(ov[3:2]), 32'h3);
        chk("ls_pair_d1", 32'(od[2]), 32'h11);
        chk("ls_pair_d2", 32'(od[3]), 32'h22);
        iv = 2'b00;
        cycle();
        chk("ls_hold_v", 32'(ov[3:2]), 32'h3);
        chk("ls_hold_d1", 32'(od[2]), 32'h11);
        ordy = 2'b11;
        cycle();
        chk("ls_pop_v", 32'(ov[3:2]), 32'h0);

        // Reset with both lanes full.
        ordy = 2'b00;
        iv   = 2'b11;
        id0  = 8'h31;
        id1  = 8'h41;
        cycle();
        id0 = 8'h32;
        id1 = 8'h42;
        cycle();
        chk("full_ready", 32'(ir[1:0]), 32'h0);
        chk("full_d1", 32'(od[0]), 32'h31);
        chk("full_d2", 32'(od[1]), 32'h41);
        iv = 2'b00;
        pulse_reset();
        ordy = 2'b11;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("post_rst_v", 32'(ov[1:0]), 32'h0);
        end
        iv  = 2'b01;
        id0 = 8'h55;
        cycle();
        chk("resume_v", 32'(ov[0]), 32'd1);
        chk("resume_d", 32'(od[0]), 32'h55);
        iv = 2'b00;
        cycle();

        // Random traffic on both instances.
        for (int c = 0; c < 10000; c++) begin
            iv   = 2'($urandom_range(0, 3));
            ordy = 2'($urandom_range(0, 3));
            id0  = 8'($urandom);
            id1  = 8'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
